// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data stages share one memory port.
// Data normally wins contention; a starvation counter guarantees fetch progress.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        ivalid,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dvalid,
    output logic        err,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    input  logic [31:0] mrdata,
    input  logic        mready,
    output logic        stallF,
    output logic        stallM
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } state_t;

    localparam logic [2:0] STARVE_MAX  = 3'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  starve_cnt_r;
    logic [2:0]  starve_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic        grant_d_s;
    logic        grant_i_s;
    logic        busy_s;
    logic        timeout_s;
    logic        done_s;

    // Arbitration in IDLE: data first unless fetch has waited STARVE_LIMIT grants.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (dreq && !(ireq && (starve_cnt_r == STARVE_MAX))) begin
                grant_d_s = 1'b1;
            end else if (ireq) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Transaction end: either the memory answered or the wait budget ran out.
    always_comb begin
        busy_s    = (state_r != IDLE);
        timeout_s = busy_s && !mready && (wait_cnt_r == TIMEOUT_CNT);
        done_s    = busy_s && (mready || timeout_s);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = DBUSY;
                end else if (grant_i_s) begin
                    state_nxt_s = IBUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IBUSY, DBUSY: begin
                if (done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Starvation and wait counter updates.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        wait_nxt_s   = wait_cnt_r;
        if (grant_i_s) begin
            starve_nxt_s = 3'd0;
        end else if (grant_d_s && ireq && (starve_cnt_r < STARVE_MAX)) begin
            starve_nxt_s = starve_cnt_r + 3'd1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
        // The counter never wraps: at TIMEOUT the transaction always ends.
        if (!busy_s || done_s) begin
            wait_nxt_s = 8'd0;
        end else begin
            wait_nxt_s = wait_cnt_r + 8'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            starve_cnt_r <= 3'd0;
            wait_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            wait_cnt_r   <= wait_nxt_s;
        end
    end

    // Request latches captured at grant time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
        end else if (grant_d_s) begin
            addr_r  <= daddr;
            wdata_r <= dwdata;
            we_r    <= dwe;
        end else if (grant_i_s) begin
            addr_r  <= iaddr;
            wdata_r <= wdata_r;
            we_r    <= 1'b0;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    // Memory port, completion strobes and stall requests.
    always_comb begin
        mreq   = busy_s;
        mwe    = we_r && (state_r == DBUSY);
        maddr  = addr_r;
        mwdata = wdata_r;
        ivalid = done_s && (state_r == IBUSY);
        dvalid = done_s && (state_r == DBUSY);
        err    = timeout_s;
        irdata = (ivalid && !timeout_s) ? mrdata : 32'd0;
        drdata = (dvalid && !timeout_s) ? mrdata : 32'd0;
        stallF = ireq && !ivalid;
        stallM = dreq && !dvalid;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe, mready;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic        ivalid, dvalid, err, mreq, mwe, stallF, stallM;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: at most one outstanding memory transaction.
    bit          m_busy;
    bit          m_isdata;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_wait;
    int          m_starve;
    bit          e_iv, e_dv;
    bit          o_iv, o_dv, o_mreq, o_err;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dvalid(dvalid), .err(err),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mready(mready),
        .stallF(stallF), .stallM(stallM)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic model_step();
        bit          done, tmo;
        logic [31:0] rd;
        if (reset) begin
            m_busy = 0; m_starve = 0; m_wait = 0;
            m_addr = 32'd0; m_wdata = 32'd0; m_we = 0;
        end
        tmo  = m_busy && !mready && (m_wait == TO);
        done = m_busy && (mready || tmo);
        e_iv = done && !m_isdata;
        e_dv = done && m_isdata;
        rd   = tmo ? 32'd0 : mrdata;
        o_iv = ivalid; o_dv = dvalid; o_mreq = mreq; o_err = err;
        check_val("mreq",   {31'd0, mreq},   {31'd0, m_busy});
        check_val("mwe",    {31'd0, mwe},    {31'd0, m_busy && m_isdata && m_we});
        check_val("maddr",  maddr,  m_addr);
        check_val("mwdata", mwdata, m_wdata);
        check_val("ivalid", {31'd0, ivalid}, {31'd0, e_iv});
        check_val("dvalid", {31'd0, dvalid}, {31'd0, e_dv});
        check_val("err",    {31'd0, err},    {31'd0, tmo});
        if (e_iv) check_val("irdata", irdata, rd);
        if (e_dv) check_val("drdata", drdata, rd);
        check_val("stallF", {31'd0, stallF}, {31'd0, ireq && !e_iv});
        check_val("stallM", {31'd0, stallM}, {31'd0, dreq && !e_dv});
        check_val("starve", {29'd0, dut.starve_cnt_r}, 32'(m_starve));
        if (!reset) begin
            if (m_busy) begin
                if (done) m_busy = 0;
                else m_wait++;
            end else if (dreq && !(ireq && m_starve == SL)) begin
                m_busy = 1; m_isdata = 1; m_wait = 0;
                m_addr = daddr; m_wdata = dwdata; m_we = dwe;
                if (ireq && m_starve < SL) m_starve++;
            end else if (ireq) begin
                m_busy = 1; m_isdata = 0; m_wait = 0;
                m_addr = iaddr; m_starve = 0;
            end
        end
    endtask

    // Inputs are set at a falling edge; outputs are sampled 1 time unit later.
    task automatic cycle();
        #1;
        model_step();
        @(negedge clk);
    endtask

    initial begin
        int  n_d, n_busy;
        bit  got, got_err;
        bit  pend_i, pend_d;
        int  thr;

        reset = 1'b1; ireq = 0; dreq = 0; dwe = 0; mready = 0;
        iaddr = 32'd0; daddr = 32'd0; dwdata = 32'd0; mrdata = 32'd0;
        @(negedge clk);
        cycle(); cycle();
        reset = 1'b0;
        cycle();

        // Single fetch, minimum latency.
        ireq = 1; iaddr = 32'h0000_0040; mrdata = $urandom;
        cycle();
        mready = 1; mrdata = 32'h1234_5678;
        cycle();
        check_val("fetch_done", {31'd0, o_iv}, 32'd1);
        ireq = 0; mready = 0;
        cycle();

        // Collision: data write first, then fetch.
        ireq = 1; iaddr = 32'h200; dreq = 1; dwe = 1; daddr = 32'h100;
        dwdata = 32'hCAFE_0001; mready = 1;
        for (int i = 0; i < 6; i++) begin
            mrdata = $urandom;
            cycle();
            if (e_dv) dreq = 0;
            if (e_iv) ireq = 0;
        end
        dwe = 0;

        // Starvation: data continuously requested while fetch waits.
        ireq = 1; iaddr = 32'h300; dreq = 1; daddr = 32'h400; mready = 1;
        n_d = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            mrdata = $urandom;
            cycle();
            if (o_dv) n_d++;
            if (o_iv) got = 1;
        end
        check_val("starve_fetch_seen", {31'd0, got}, 32'd1);
        check_val("starve_data_grants", 32'(n_d), 32'(SL));
        ireq = 0; dreq = 0;
        cycle();

        // Timeout on a data read.
        dreq = 1; dwe = 0; daddr = 32'h500; mready = 0; mrdata = 32'hDEAD_BEEF;
        n_busy = 0; got = 0; got_err = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (o_dv) begin got = 1; got_err = o_err; end
            else if (o_mreq) n_busy++;
        end
        check_val("timeout_seen", {31'd0, got}, 32'd1);
        check_val("timeout_busy_cycles", 32'(n_busy), 32'(TO));
        check_val("timeout_err", {31'd0, got_err}, 32'd1);
        dreq = 0;
        cycle();

        // Reset while in DBUSY.
        dreq = 1; dwe = 1; daddr = 32'h600; dwdata = 32'h0BAD_F00D; mready = 0;
        cycle(); cycle();
        reset = 1;
        cycle();
        check_val("reset_mreq", {31'd0, o_mreq}, 32'd0);
        check_val("reset_dvalid", {31'd0, o_dv}, 32'd0);
        reset = 0; dreq = 0; dwe = 0; ireq = 1; iaddr = 32'h700; mready = 1;
        cycle(); cycle();
        check_val("post_reset_fetch", {31'd0, o_iv}, 32'd1);
        ireq = 0;
        cycle();

        // Wait states: three cycles without mready.
        ireq = 1; iaddr = 32'h800; mready = 0;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        mready = 1; mrdata = 32'hA5A5_0003;
        cycle();
        check_val("wait_state_valid", {31'd0, o_iv}, 32'd1);
        ireq = 0; mready = 0;
        cycle();

        // Request dropped mid-flight still completes.
        dreq = 1; dwe = 0; daddr = 32'h900;
        cycle();
        dreq = 0; mready = 1;
        cycle();
        check_val("drop_completes", {31'd0, o_dv}, 32'd1);
        mready = 0;
        cycle();

        // Randomized traffic.
        pend_i = 0; pend_d = 0; thr = 8;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) thr = $urandom_range(0, 8);
            reset = ($urandom % 400 == 0);
            if (!pend_i && ($urandom % 3 == 0)) begin
                pend_i = 1; ireq = 1; iaddr = $urandom;
            end
            if (!pend_d && ($urandom % 2 == 0)) begin
                pend_d = 1; dreq = 1; daddr = $urandom; dwdata = $urandom; dwe = $urandom;
            end
            mready = (($urandom % 8) < thr);
            mrdata = $urandom;
            cycle();
            if (e_iv) begin pend_i = 0; ireq = 0; end
            if (e_dv) begin pend_d = 0; dreq = 0; end
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
